// File: rtl/spi_receiver.sv
// SPI slave receiver: synchronizes sck/sce/mosi/dc_in into clk and assembles MSB-first words.
// Build option SPI_RECEIVER_OVERRUN_EN: drop unconsumed-word overwrites and flag overrun.
module spi_receiver #(
  parameter int DATA_SIZE    = 8,
  parameter int COUNTER_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sck,
  input  logic                 sce,
  input  logic                 mosi,
  input  logic                 dc_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 dc_out,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 frame_done,
  output logic                 overrun
);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t                  state;
  logic                    sck_s1, sck_s2, sck_d;
  logic                    sce_s1, sce_s2;
  logic                    mosi_s1, mosi_s2;
  logic                    dc_s1, dc_s2;
  logic [DATA_SIZE-2:0]    shift;
  logic [COUNTER_SIZE-1:0] cnt;
  logic                    sck_rise;
  logic                    last_bit;
  logic [DATA_SIZE-1:0]    word;

  assign sck_rise = sck_s2 & ~sck_d;
  assign last_bit = cnt == COUNTER_SIZE'(DATA_SIZE - 1);
  assign word     = {shift, mosi_s2};

  // sck/sce idle high, so their flops reset to 1 to avoid a false edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s1  <= 1'b1;
      sck_s2  <= 1'b1;
      sck_d   <= 1'b1;
      sce_s1  <= 1'b1;
      sce_s2  <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      dc_s1   <= 1'b0;
      dc_s2   <= 1'b0;
    end else begin
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      sce_s1  <= sce;
      sce_s2  <= sce_s1;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      dc_s1   <= dc_in;
      dc_s2   <= dc_s1;
    end
  end

`ifndef SPI_RECEIVER_OVERRUN_EN
  assign overrun = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      cnt        <= '0;
      data_out   <= '0;
      dc_out     <= 1'b0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
`ifdef SPI_RECEIVER_OVERRUN_EN
      overrun    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (data_ack) begin
        data_valid <= 1'b0;
`ifdef SPI_RECEIVER_OVERRUN_EN
        overrun    <= 1'b0;
`endif
      end
      unique case (state)
        IDLE: begin
          if (!sce_s2) begin
            state <= RECV;
            cnt   <= '0;
            shift <= '0;
          end
        end
        RECV: begin
          if (sce_s2) begin
            state      <= IDLE;
            cnt        <= '0;
            frame_done <= 1'b1;
          end else if (sck_rise) begin
            shift <= word[DATA_SIZE-2:0];
            if (last_bit) begin
              cnt <= '0;
`ifdef SPI_RECEIVER_OVERRUN_EN
              if (data_valid && !data_ack) begin
                overrun <= 1'b1;
              end else begin
                data_out   <= word;
                dc_out     <= dc_s2;
                data_valid <= 1'b1;
              end
`else
              data_out   <= word;
              dc_out     <= dc_s2;
              data_valid <= 1'b1;
`endif
            end else begin
              cnt <= cnt + COUNTER_SIZE'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_receiver.sv
// Directed + random bench for spi_receiver against a word-level model.
module tb_spi_receiver;

`ifdef SPI_RECEIVER_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b1;
  logic       sce = 1'b1;
  logic       mosi = 1'b0;
  logic       dc_in = 1'b0;
  logic [7:0] data_out;
  logic       dc_out;
  logic       data_valid;
  logic       data_ack = 1'b0;
  logic       frame_done;
  logic       overrun;

  int total = 0;
  int bad = 0;

  logic [7:0] m_data = 8'h00;
  logic       m_dc = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;

  spi_receiver #(.DATA_SIZE(8), .COUNTER_SIZE(4)) dut (
    .clk(clk),
    .rst(rst),
    .sck(sck),
    .sce(sce),
    .mosi(mosi),
    .dc_in(dc_in),
    .data_out(data_out),
    .dc_out(dc_out),
    .data_valid(data_valid),
    .data_ack(data_ack),
    .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".data"}, 32'(data_out), 32'(m_data));
    check({tag, ".dc"}, 32'(dc_out), 32'(m_dc));
    check({tag, ".valid"}, 32'(data_valid), 32'(m_valid));
    check({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_dc    = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // sck period = 8 clk; mosi changes on the falling half
  task automatic send_bits(input logic [7:0] v, input int n,
                           input logic dc, input bit ack_last);
    dc_in = dc;
    for (int i = 0; i < n; i++) begin
      sck  = 1'b0;
      mosi = v[7-i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      if (ack_last && i == n - 1) begin
        repeat (2) @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
    end
    if (n == 8) begin
      if (!m_valid || ack_last || !OVR) begin
        m_data  = v;
        m_dc    = dc;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
      if (ack_last && OVR) m_ovr = 1'b0;
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    m_valid = 1'b0;
    if (OVR) m_ovr = 1'b0;
  endtask

  task automatic frame_begin();
    sce = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end(input string tag);
    int pulses;
    pulses = 0;
    sce = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) pulses++;
    end
    check({tag, ".frame_done"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    int nb;
    logic [7:0] v;
    logic d;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outs("reset");
    check("reset.frame_done", 32'(frame_done), 32'd0);

    frame_begin();
    send_bits(8'hA5, 8, 1'b1, 1'b0);
    check_outs("a5");
    do_ack();
    frame_end("a5");

    frame_begin();
    send_bits(8'h21, 8, 1'b0, 1'b0);
    check_outs("w21");
    do_ack();
    check("w21.acked", 32'(data_valid), 32'd0);
    send_bits(8'hC8, 8, 1'b0, 1'b0);
    check_outs("wc8");
    do_ack();
    frame_end("w21c8");

    frame_begin();
    send_bits(8'hFF, 5, 1'b1, 1'b0);
    frame_end("partial");
    check_outs("partial");
    frame_begin();
    send_bits(8'h3C, 8, 1'b1, 1'b0);
    check_outs("w3c");
    do_ack();
    frame_end("w3c");

    frame_begin();
    send_bits(8'h11, 8, 1'b1, 1'b0);
    send_bits(8'h22, 8, 1'b0, 1'b0);
    check_outs("noack");
    do_ack();
    check_outs("noack.acked");
    frame_end("noack");

    frame_begin();
    send_bits(8'h44, 8, 1'b0, 1'b0);
    send_bits(8'h55, 8, 1'b1, 1'b1);
    check_outs("ack_same");
    do_ack();
    frame_end("ack_same");

    frame_begin();
    send_bits(8'h99, 4, 1'b1, 1'b0);
    rst = 1'b1;
    sce = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    check_outs("midrst");
    check("midrst.frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    frame_begin();
    send_bits(8'h99, 8, 1'b1, 1'b0);
    check_outs("w99");
    do_ack();
    frame_end("w99");

    for (int f = 0; f < 6; f++) begin
      frame_begin();
      nb = int'($urandom_range(1, 3));
      for (int b = 0; b < nb; b++) begin
        v = 8'($urandom);
        d = 1'($urandom);
        send_bits(v, 8, d, ($urandom_range(0, 3) == 0));
        check_outs($sformatf("rnd%0d_%0d", f, b));
        if ($urandom_range(0, 1) == 1) do_ack();
      end
      frame_end($sformatf("rnd%0d", f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_receiver.md
SPI_RECEIVER -- requirements
Module: spi_receiver

Interface
REQ-001 Parameter DATA_SIZE, default 8, bits per transferred word.
REQ-002 Parameter COUNTER_SIZE, default 4, width of the bit counter; SHALL satisfy 2^COUNTER_SIZE > DATA_SIZE.
REQ-003 clk  input  1  system clock; all logic SHALL run on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sck  input  1  serial clock from the external master, asynchronous to clk.
REQ-006 sce  input  1  chip enable from the master, active low, asynchronous.
REQ-007 mosi  input  1  serial data from the master, MSB first.
REQ-008 dc_in  input  1  data/command flag from the master (1 = data, 0 = command).
REQ-009 data_out  output  DATA_SIZE  last completed received word.
REQ-010 dc_out  output  1  dc_in value captured with data_out.
REQ-011 data_valid  output  1  high while data_out holds an unconsumed word.
REQ-012 data_ack  input  1  consumer acknowledge; pulse of one or more clk cycles.
REQ-013 frame_done  output  1  one-clk pulse when sce deasserts.
REQ-014 overrun  output  1  sticky overrun flag (see Configuration).

Function
REQ-015 sck, sce, mosi and dc_in SHALL each pass through a two-flop synchronizer to clk before use.
REQ-016 A sck rising edge SHALL be detected as synchronized sck = 1 with its previous sample = 0; sampling SHALL occur only on that edge.
REQ-017 The master's sck high and low phases SHALL each last at least 3 clk periods; faster sck is out of contract.
REQ-018 State machine: IDLE (synchronized sce = 1) and RECV (synchronized sce = 0); IDLE->RECV on sce falling, RECV->IDLE on sce rising.
REQ-019 In RECV, each detected sck rising edge SHALL shift synchronized mosi into the LSB of the shift register and increment the bit counter.
REQ-020 When the counter reaches DATA_SIZE, on the same clk cycle the shift result SHALL load into data_out, synchronized dc_in SHALL load into dc_out, data_valid SHALL set, and the counter SHALL clear to 0.
REQ-021 Latency: data_valid SHALL rise no later than 4 clk cycles after the raw sck rising edge carrying the last bit.
REQ-022 Consecutive words within one sce-low frame SHALL be received back to back without gaps.
REQ-023 RECV->IDLE with counter nonzero SHALL discard the partial word and clear the counter; data_out, dc_out and data_valid SHALL be unchanged.
REQ-024 frame_done SHALL pulse for exactly one clk cycle on each RECV->IDLE transition.
REQ-025 data_ack high with data_valid high SHALL clear data_valid on the next clk edge; data_ack with data_valid low SHALL be ignored.
REQ-026 Simultaneous word completion and data_ack: the new word SHALL load and data_valid SHALL remain high.

Reset
REQ-027 Under rst: state = IDLE, shift register = 0, counter = 0, data_out = 0, dc_out = 0, data_valid = 0, frame_done = 0, overrun = 0, synchronizer flops = 1 for sck and sce and 0 for mosi and dc_in.
REQ-028 rst asserted mid-word SHALL abandon the word; after release the block SHALL wait for a new sce falling edge before receiving.

Configuration
REQ-029 Macro SPI_RECEIVER_OVERRUN_EN.
REQ-030 Defined: a word completing while data_valid = 1 and data_ack = 0 SHALL be dropped, data_out and dc_out SHALL be held, and overrun SHALL set and stay set until rst or a data_ack.
REQ-031 Not defined: such a word SHALL overwrite data_out and dc_out, data_valid SHALL stay high, and overrun SHALL be tied to 0.

Verification
REQ-032 Reset then sce low, byte 0xA5 with dc_in = 1, sck = clk/8 -> data_out = 0xA5, dc_out = 1, data_valid = 1 within 4 clk of the 8th edge.
REQ-033 Frame 0x21, 0xC8 with dc_in = 0, ack after each word -> two valid words in order with dc_out = 0, then one frame_done pulse after sce rises.
REQ-034 sce rises after 5 bits of 0xFF, then full byte 0x3C -> no valid after the partial word; next data_out = 0x3C.
REQ-035 Two bytes 0x11, 0x22 with no ack -> macro defined: data_out = 0x11, overrun = 1; macro undefined: data_out = 0x22, overrun = 0.
REQ-036 data_ack on the same clk as completion of a second byte 0x55 -> data_out = 0x55, data_valid = 1, overrun = 0.
REQ-037 rst pulsed after 4 bits -> all outputs at reset values; a following byte 0x99 is received correctly.
